// File: rtl/imem_fetch_if.sv
// Fetch-side instruction memory interface: one read per fetch PC over req/gnt + rvalid,
// presents the word as InstrF and stalls fetch until it is available.
module imem_fetch_if #(
  parameter int unsigned     XLEN = 32,
  parameter logic [XLEN-1:0] NOP  = 'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  input  logic            StallF,
  input  logic            RedirectE,
  output logic [XLEN-1:0] InstrF,
  output logic            FetchStall,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemGnt,
  input  logic            ImemRvalid,
  input  logic [XLEN-1:0] ImemRdata
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2,
    StDrop = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_hold;
  logic            w_hold_load;
  logic            w_req;
  logic            w_stall;
  logic [XLEN-1:0] w_instr;
  logic            w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^PCF[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_hold_load = 1'b0;
    w_req       = 1'b0;
    w_stall     = 1'b1;
    w_instr     = NOP;
    unique case (r_state)
      StIdle: begin
        w_req = 1'b1;
        if (ImemGnt) begin
          // A grant in the redirect cycle fetched a stale PC; its response must be swallowed.
          w_state_nxt = RedirectE ? StDrop : StWait;
        end
      end
      StWait: begin
        if (RedirectE) begin
          w_state_nxt = ImemRvalid ? StIdle : StDrop;
        end else if (ImemRvalid) begin
          w_instr = ImemRdata;
          w_stall = 1'b0;
          if (StallF) begin
            w_hold_load = 1'b1;
            w_state_nxt = StHold;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      StHold: begin
        w_instr = r_hold;
        w_stall = 1'b0;
        if (RedirectE || !StallF) begin
          w_state_nxt = StIdle;
        end
      end
      StDrop: begin
        if (ImemRvalid) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Reset is asynchronous, so outputs are gated directly rather than waiting for an edge.
  assign ImemReq    = reset & w_req;
  assign FetchStall = ~reset | w_stall;
  assign InstrF     = reset ? w_instr : NOP;
  assign ImemAddr   = {PCF[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_hold  <= NOP;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_load) begin
        r_hold <= ImemRdata;
      end
    end
  end

  // Protocol checks (simulation only).
`ifndef SYNTHESIS
  logic r_req_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_pending <= 1'b0;
    end else begin
      r_req_pending <= ImemReq & ~ImemGnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(ImemRvalid && (r_state == StIdle || r_state == StHold)))
        else $error("imem_fetch_if: rvalid with no outstanding request");
      assert (!r_req_pending || ImemReq)
        else $error("imem_fetch_if: ungranted request retracted");
    end
  end
`endif

endmodule
